// File: rtl/weightbuffer_loader_pkg.sv
// Shared types and sizing for the weight-buffer loader: state encoding, word type,
// default geometry (512 channels, 2 staggers, 3x3 kernel).
package weightbuffer_loader_pkg;

  localparam int N_I_DEF            = 512;
  localparam int WEIGHT_STAGGER_DEF = 2;
  localparam int K_DEF              = 3;

  localparam int LANES     = N_I_DEF / WEIGHT_STAGGER_DEF;
  localparam int WORDS_MAX = WEIGHT_STAGGER_DEF * K_DEF * K_DEF;

  typedef enum logic [1:0] {
    LS_IDLE  = 2'd0,
    LS_FLUSH = 2'd1,
    LS_LOAD  = 2'd2,
    LS_DONE  = 2'd3
  } loader_state_e;

  typedef logic [0:LANES-1][1:0] weight_word_t;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/weightbuffer_load_counter.sv
// Nested stagger/row/column slot counter (k2 fastest); advances one slot per cycle of adv_i.
// last_o flags the final slot of an n_i-stagger load; clear_i wins over adv_i.
module weightbuffer_load_counter
  import weightbuffer_loader_pkg::*;
#(
  parameter  int WEIGHT_STAGGER = 2,
  parameter  int K              = 3,
  localparam int SW             = clog2_min1(WEIGHT_STAGGER),
  localparam int KW             = clog2_min1(K),
  localparam int NW             = $clog2(WEIGHT_STAGGER + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          adv_i,
  input  logic [NW-1:0] n_i,
  output logic [SW-1:0] s_o,
  output logic [KW-1:0] k1_o,
  output logic [KW-1:0] k2_o,
  output logic          last_o
);

  logic [SW-1:0] s_q, s_d;
  logic [KW-1:0] k1_q, k1_d;
  logic [KW-1:0] k2_q, k2_d;
  logic          k2_wrap, k1_wrap, s_wrap;

  assign k2_wrap = (k2_q == KW'(K - 1));
  assign k1_wrap = (k1_q == KW'(K - 1));
  assign s_wrap  = (s_q == SW'(WEIGHT_STAGGER - 1));

  always_comb begin
    s_d  = s_q;
    k1_d = k1_q;
    k2_d = k2_q;
    if (clear_i) begin
      s_d  = '0;
      k1_d = '0;
      k2_d = '0;
    end else if (adv_i) begin
      k2_d = k2_wrap ? '0 : k2_q + KW'(1);
      if (k2_wrap) begin
        k1_d = k1_wrap ? '0 : k1_q + KW'(1);
        if (k1_wrap) begin
          s_d = s_wrap ? '0 : s_q + SW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_q  <= '0;
      k1_q <= '0;
      k2_q <= '0;
    end else begin
      s_q  <= s_d;
      k1_q <= k1_d;
      k2_q <= k2_d;
    end
  end

  assign s_o    = s_q;
  assign k1_o   = k1_q;
  assign k2_o   = k2_q;
  assign last_o = k2_wrap && k1_wrap && ((int'(s_q) + 1) == int'(n_i));

endmodule

// File: rtl/weightbuffer_loader.sv
// Flushes the target set, then streams n*K*K words into it with one-hot save strobes; start-to-done n*K*K+2 cycles.
// Ready is a pure state decode (LOAD and no abort); valid stalls only delay the slot counter.
module weightbuffer_loader
  import weightbuffer_loader_pkg::*;
#(
  parameter  int N_I            = N_I_DEF,
  parameter  int WEIGHT_STAGGER = WEIGHT_STAGGER_DEF,
  parameter  int K              = K_DEF,
  localparam int LW             = N_I / WEIGHT_STAGGER,
  localparam int NW             = $clog2(WEIGHT_STAGGER + 1),
  localparam int SW             = clog2_min1(WEIGHT_STAGGER),
  localparam int KW             = clog2_min1(K)
) (
  input  logic                                                clk_i,
  input  logic                                                rst_ni,
  input  logic                                                start_i,
  input  logic                                                set_i,
  input  logic [NW-1:0]                                       stagger_count_i,
  input  logic                                                abort_i,
  input  logic                                                weight_valid_i,
  output logic                                                weight_ready_o,
  input  logic [0:LW-1][1:0]                                  weight_data_i,
  output logic [0:LW-1][1:0]                                  data_o,
  output logic [0:1][0:WEIGHT_STAGGER-1][0:K-1][0:K-1]        save_enable_o,
  output logic [0:1][0:WEIGHT_STAGGER-1]                      flush_o,
  output logic                                                busy_o,
  output logic                                                done_o
);

  localparam logic [1:0] ST_IDLE  = 2'(LS_IDLE);
  localparam logic [1:0] ST_FLUSH = 2'(LS_FLUSH);
  localparam logic [1:0] ST_LOAD  = 2'(LS_LOAD);
  localparam logic [1:0] ST_DONE  = 2'(LS_DONE);

  logic [1:0]    state_q, state_d;
  logic          set_q, set_d;
  logic [NW-1:0] n_q, n_d;
  logic [0:LW-1][1:0] data_q, data_d;
  logic [0:1][0:WEIGHT_STAGGER-1][0:K-1][0:K-1] save_q, save_d;

  logic          hs;
  logic          cnt_clear;
  logic          cnt_last;
  logic [SW-1:0] cnt_s;
  logic [KW-1:0] cnt_k1, cnt_k2;

  assign weight_ready_o = (state_q == ST_LOAD) && !abort_i;
  assign hs             = weight_valid_i && weight_ready_o;
  assign cnt_clear      = abort_i || (state_q == ST_IDLE);

  weightbuffer_load_counter #(
    .WEIGHT_STAGGER (WEIGHT_STAGGER),
    .K              (K)
  ) u_counter (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (cnt_clear),
    .adv_i   (hs),
    .n_i     (n_q),
    .s_o     (cnt_s),
    .k1_o    (cnt_k1),
    .k2_o    (cnt_k2),
    .last_o  (cnt_last)
  );

  always_comb begin
    state_d = state_q;
    set_d   = set_q;
    n_d     = n_q;
    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_d = ST_FLUSH;
            set_d   = set_i;
            n_d     = (stagger_count_i > NW'(WEIGHT_STAGGER)) ? NW'(WEIGHT_STAGGER)
                                                              : stagger_count_i;
          end
        end
        ST_FLUSH: state_d = (n_q == '0) ? ST_DONE : ST_LOAD;
        ST_LOAD:  if (hs && cnt_last) state_d = ST_DONE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Strobe and data register the accepted slot; an abort never cancels an already-registered strobe.
  always_comb begin
    save_d = '0;
    data_d = data_q;
    if (hs) begin
      save_d[set_q][cnt_s][cnt_k1][cnt_k2] = 1'b1;
      data_d = weight_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      set_q   <= 1'b0;
      n_q     <= '0;
      data_q  <= '0;
      save_q  <= '0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      n_q     <= n_d;
      data_q  <= data_d;
      save_q  <= save_d;
    end
  end

  always_comb begin
    flush_o = '0;
    if (state_q == ST_FLUSH) flush_o[set_q] = '1;
  end

  assign data_o        = data_q;
  assign save_enable_o = save_q;
  assign busy_o        = (state_q != ST_IDLE);
  assign done_o        = (state_q == ST_DONE);

endmodule

// File: tb/tb_weightbuffer_loader.sv
// Cycle-level bench for weightbuffer_loader: randomized words/valid patterns checked against a
// word-count reference model (slot derived arithmetically from the consumed-word index).
module tb_weightbuffer_loader;
  import weightbuffer_loader_pkg::*;

  localparam int WS = WEIGHT_STAGGER_DEF;
  localparam int KK = K_DEF;

  logic clk;
  logic rst_n, start, set, abort, valid, ready, busy, done;
  logic [1:0] scnt;
  weight_word_t wdata, data_o;
  logic [0:1][0:WS-1][0:KK-1][0:KK-1] save;
  logic [0:1][0:WS-1] flush;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  weightbuffer_loader dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .start_i         (start),
    .set_i           (set),
    .stagger_count_i (scnt),
    .abort_i         (abort),
    .weight_valid_i  (valid),
    .weight_ready_o  (ready),
    .weight_data_i   (wdata),
    .data_o          (data_o),
    .save_enable_o   (save),
    .flush_o         (flush),
    .busy_o          (busy),
    .done_o          (done)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: phase 0 idle, 1 flush, 2 load, 3 done.
  int m_phase, m_set, m_n, m_cnt;
  logic [0:1][0:WS-1][0:KK-1][0:KK-1] m_save;
  weight_word_t m_data;
  weight_word_t words [WORDS_MAX];
  int strobes, dones, done_cyc, cyc_n;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_set = 0; m_n = 0;
    m_save = '0; m_data = '0;
  endtask

  task automatic cyc(input logic st, input logic se, input logic [1:0] sc,
                     input logic ab, input logic va);
    logic [0:1][0:WS-1] ef;
    logic er, hs;
    int s, k1, k2;
    @(negedge clk);
    start = st; set = se; scnt = sc; abort = ab; valid = va;
    wdata = words[m_cnt % WORDS_MAX];
    #1;
    er = (m_phase == 2) && !ab && rst_n;
    ef = '0;
    if (m_phase == 1) ef[m_set] = '1;
    chk("ready", 512'(ready), 512'(er));
    chk("busy",  512'(busy),  512'(m_phase != 0));
    chk("done",  512'(done),  512'(m_phase == 3));
    chk("flush", 512'(flush), 512'(ef));
    chk("save",  512'(save),  512'(m_save));
    chk("data",  512'(data_o), 512'(m_data));
    if (|save) strobes++;
    if (done) begin dones++; done_cyc = cyc_n; end
    hs = er && va;
    m_save = '0;
    if (hs) begin
      s  = m_cnt / (KK * KK);
      k1 = (m_cnt / KK) % KK;
      k2 = m_cnt % KK;
      m_save[m_set][s][k1][k2] = 1'b1;
      m_data = wdata;
    end
    if (!rst_n) begin
      model_reset();
    end else if (ab) begin
      m_phase = 0; m_cnt = 0;
    end else begin
      case (m_phase)
        0: if (st) begin
             m_set = int'(se); m_n = (int'(sc) > WS) ? WS : int'(sc);
             m_cnt = 0; m_phase = 1;
           end
        1: m_phase = (m_n == 0) ? 3 : 2;
        2: if (hs) begin
             m_cnt++;
             if (m_cnt == m_n * KK * KK) m_phase = 3;
           end
        default: m_phase = 0;
      endcase
    end
    cyc_n++;
  endtask

  task automatic fill_random();
    for (int i = 0; i < WORDS_MAX; i++)
      for (int j = 0; j < LANES / 16; j++)
        words[i][j*16 +: 16] = $urandom;
  endtask

  // vmode: 0 continuous, 1 every third cycle, 2 random, 3 continuous plus start pulse during LOAD.
  task automatic run_job(input logic se, input logic [1:0] sc, input int vmode, input int abort_after);
    int st_cyc, bound, n_exp;
    logic va, st;
    strobes = 0; dones = 0; done_cyc = -1;
    st_cyc = cyc_n;
    cyc(1'b1, se, sc, 1'b0, vmode == 3);
    bound = 0;
    while (m_phase != 0 && bound < 300) begin
      case (vmode)
        1:       va = (cyc_n % 3) == 0;
        2:       va = 1'($urandom_range(0, 1));
        default: va = 1'b1;
      endcase
      st = (vmode == 3) && (m_phase == 2) && (m_cnt == 4);
      if (abort_after > 0 && m_phase == 2 && m_cnt == abort_after)
        cyc(1'b0, se, sc, 1'b1, va);
      else
        cyc(st, ~se, 2'd1, 1'b0, va);
      bound++;
    end
    chk("job_bound", 512'(bound < 300), 512'(1));
    n_exp = ((int'(sc) > WS) ? WS : int'(sc)) * KK * KK;
    if (abort_after > 0) begin
      chk("abort_strobes", 512'(strobes), 512'(abort_after));
      chk("abort_dones", 512'(dones), 512'(0));
    end else begin
      chk("job_strobes", 512'(strobes), 512'(n_exp));
      chk("job_dones", 512'(dones), 512'(1));
      if (vmode == 0 || vmode == 3)
        chk("done_cycle", 512'(done_cyc - st_cyc), 512'(n_exp + 2));
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; set = 1'b0; scnt = '0; abort = 1'b0; valid = 1'b0;
    wdata = '0; cyc_n = 0; strobes = 0; dones = 0; done_cyc = -1;
    model_reset();
    for (int i = 0; i < WORDS_MAX; i++) words[i] = weight_word_t'(i);
    cyc(1'b1, 1'b1, 2'd2, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Full load into set 1, words 0..17.
    run_job(1'b1, 2'd2, 0, 0);
    cyc(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

    fill_random();
    run_job(1'($urandom_range(0, 1)), 2'd1, 1, 0);
    run_job(1'b0, 2'd0, 0, 0);
    fill_random();
    run_job(1'b1, 2'd3, 2, 0);
    run_job(1'b1, 2'd2, 0, 5);
    fill_random();
    run_job(1'b0, 2'd2, 2, 0);

    // Asynchronous reset in the middle of a load with valid held high.
    cyc(1'b1, 1'b1, 2'd2, 1'b0, 1'b1);
    while (m_phase != 2 || m_cnt < 4) cyc(1'b0, 1'b1, 2'd2, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_save",  512'(save), 512'(0));
    chk("rst_data",  512'(data_o), 512'(0));
    chk("rst_ready", 512'(ready), 512'(0));
    chk("rst_busy",  512'({busy, done, flush}), 512'(0));
    model_reset();
    cyc(1'b0, 1'b1, 2'd2, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    strobes = 0;
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 2'd2, 1'b0, 1'b1);
    chk("post_rst_strobes", 512'(strobes), 512'(0));

    // Valid during IDLE/FLUSH and a start pulse inside LOAD are both ignored.
    fill_random();
    run_job(1'b1, 2'd2, 3, 0);
    cyc(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
